// File: rtl/rom_sequencer.sv
// Address sequencer and sample capture stage between the waveform ROM and the
// FIR input. Plays a programmable address window in loop, one-shot or
// ping-pong order, tracks ROM read latency with a valid pipeline and registers
// each returned sample with a one-cycle strobe.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; outputs hold, nothing issued
// S_RUN   | one address issued per enabled cycle
// S_PAUSE | enable low; address held, in-flight samples drain
// S_DONE  | one-shot finished; wait for last sample, then idle
module rom_sequencer #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 10,
  parameter int ROM_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] sample_in,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  loop_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  localparam logic [1:0]        M_ONESHOT  = 2'd1;
  localparam logic [1:0]        M_PINGPONG = 2'd2;
  localparam logic [ADDR_W-1:0] ONE_A      = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  ONE_C      = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   win_lo_q, win_lo_d;
  logic [ADDR_W-1:0]   win_hi_q, win_hi_d;
  logic [1:0]          mode_q, mode_d;
  logic                dir_dn_q, dir_dn_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cfg_err_q, cfg_err_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ROM_LAT-1:0]  vld_q, vld_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                sample_valid_q, sample_valid_d;

  logic [ADDR_W-1:0]   addr_inc, addr_dec, nxt_addr;
  logic                nxt_dir_dn, wrap_inc, last_issue;
  logic                issue, flush;

  assign addr_inc = addr_q + ONE_A;
  assign addr_dec = addr_q - ONE_A;

  // Where the address goes after issuing the current one, per playback mode.
  always_comb begin
    nxt_addr   = addr_inc;
    nxt_dir_dn = dir_dn_q;
    wrap_inc   = 1'b0;
    last_issue = 1'b0;
    case (mode_q)
      M_ONESHOT: begin
        if (addr_q == win_hi_q) begin
          nxt_addr   = addr_q;
          last_issue = 1'b1;
        end
      end
      M_PINGPONG: begin
        if (!dir_dn_q) begin
          if (addr_q == win_hi_q) begin
            if (addr_q == win_lo_q) begin
              // single-address window: reissue and count every cycle
              nxt_addr = addr_q;
              wrap_inc = 1'b1;
            end else begin
              nxt_addr   = addr_dec;
              nxt_dir_dn = 1'b1;
              wrap_inc   = (addr_dec == win_lo_q);
            end
          end
        end else begin
          if (addr_q == win_lo_q) begin
            nxt_addr   = addr_inc;
            nxt_dir_dn = 1'b0;
          end else begin
            nxt_addr = addr_dec;
            wrap_inc = (addr_dec == win_lo_q);
          end
        end
      end
      default: begin
        // loop, and the reserved mode which plays as loop
        if (addr_q == win_hi_q) begin
          nxt_addr = win_lo_q;
          wrap_inc = 1'b1;
        end
      end
    endcase
  end

  // Control FSM, issue/flush decisions and capture stage next values.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    win_lo_d       = win_lo_q;
    win_hi_d       = win_hi_q;
    mode_d         = mode_q;
    dir_dn_d       = dir_dn_q;
    cnt_d          = cnt_q;
    cfg_err_d      = cfg_err_q;
    done_d         = 1'b0;
    sample_d       = sample_q;
    issue          = 1'b0;
    flush          = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
      flush   = 1'b1;
    end else if (start) begin
      flush = 1'b1;
      if (start_addr <= end_addr) begin
        win_lo_d  = start_addr;
        win_hi_d  = end_addr;
        mode_d    = mode;
        addr_d    = start_addr;
        dir_dn_d  = 1'b0;
        cnt_d     = '0;
        cfg_err_d = 1'b0;
        state_d   = S_RUN;
      end else begin
        cfg_err_d = 1'b1;
        state_d   = S_IDLE;
      end
    end else begin
      case (state_q)
        S_RUN: begin
          if (enable) begin
            issue    = 1'b1;
            addr_d   = nxt_addr;
            dir_dn_d = nxt_dir_dn;
            if (wrap_inc && (cnt_q != CNT_MAX)) cnt_d = cnt_q + ONE_C;
            if (last_issue) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else begin
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (enable) state_d = S_RUN;
        end
        S_DONE: begin
          if (vld_q == '0) state_d = S_IDLE;
        end
        default: ;
      endcase
    end

    busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);

    vld_d = '0;
    if (!flush) begin
      vld_d[0] = issue;
      for (int i = 1; i < ROM_LAT; i++) vld_d[i] = vld_q[i-1];
    end

    sample_valid_d = vld_q[ROM_LAT-1] && !flush;
    if (sample_valid_d) sample_d = sample_in;
  end

  // All state and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      win_lo_q       <= '0;
      win_hi_q       <= '0;
      mode_q         <= '0;
      dir_dn_q       <= 1'b0;
      cnt_q          <= '0;
      cfg_err_q      <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      vld_q          <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      win_lo_q       <= win_lo_d;
      win_hi_q       <= win_hi_d;
      mode_q         <= mode_d;
      dir_dn_q       <= dir_dn_d;
      cnt_q          <= cnt_d;
      cfg_err_q      <= cfg_err_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      vld_q          <= vld_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign address      = addr_q;
  assign sample_out   = sample_q;
  assign sample_valid = sample_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;
  assign loop_count   = cnt_q;

endmodule

// File: tb/tb_rom_sequencer.sv
// Bench for rom_sequencer: window-position model plus directed scenarios.
module tb_rom_sequencer;
  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 10;
  localparam int ROM_LAT = 1;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_PAUSE = 2;
  localparam int ST_DONE  = 3;

  logic              clock;
  logic              reset;
  logic              start, stop, enable;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] start_addr, end_addr, address;
  logic [DATA_W-1:0] sample_in, sample_out;
  logic              sample_valid, busy, done, cfg_err;
  logic [CNT_W-1:0]  loop_count;

  rom_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .enable(enable),
    .mode(mode), .start_addr(start_addr), .end_addr(end_addr), .address(address),
    .sample_in(sample_in), .sample_out(sample_out), .sample_valid(sample_valid),
    .busy(busy), .done(done), .cfg_err(cfg_err), .loop_count(loop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int rom_val(input int a);
    return (a * 37 + 5) % 1024;
  endfunction

  // synchronous ROM with ROM_LAT cycles of read latency
  logic [DATA_W-1:0] rd_pipe [ROM_LAT];
  always @(posedge clock) begin
    rd_pipe[0] <= DATA_W'(rom_val(int'(address)));
    for (int i = 1; i < ROM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign sample_in = rd_pipe[ROM_LAT-1];

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: playback described by issue count k ----------------
  int m_state, m_k, m_lo, m_hi, m_mode, m_addr, m_cnt, m_sout;
  bit m_cfg, m_done, m_sv;
  bit pv [ROM_LAT];
  int pa [ROM_LAT];

  function automatic int exp_addr(input int k);
    int n, p, r;
    n = m_hi - m_lo + 1;
    if (m_mode == 1) return m_lo + ((k < n) ? k : n - 1);
    if (m_mode == 2) begin
      if (n == 1) return m_lo;
      p = 2 * (n - 1);
      r = k % p;
      return (r < n) ? m_lo + r : m_lo + p - r;
    end
    return m_lo + (k % n);
  endfunction

  function automatic int exp_cnt(input int k);
    int n, c;
    n = m_hi - m_lo + 1;
    if (m_mode == 1) c = 0;
    else if (m_mode == 2) c = (n == 1) ? k : k / (2 * (n - 1));
    else c = k / n;
    return (c > CNT_MAX) ? CNT_MAX : c;
  endfunction

  initial begin
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_state = ST_IDLE; m_k = 0; m_lo = 0; m_hi = 0; m_mode = 0;
        m_addr = 0; m_cnt = 0; m_sout = 0; m_cfg = 0; m_done = 0; m_sv = 0;
        for (int i = 0; i < ROM_LAT; i++) begin pv[i] = 0; pa[i] = 0; end
      end else begin
        bit cap, empty, iss, flush;
        int capa, ia;
        cap = pv[ROM_LAT-1];
        capa = pa[ROM_LAT-1];
        empty = 1;
        for (int i = 0; i < ROM_LAT; i++) if (pv[i]) empty = 0;
        iss = 0; ia = m_addr; flush = 0; m_done = 0;
        if (stop) begin
          m_state = ST_IDLE; flush = 1;
        end else if (start) begin
          flush = 1;
          if (int'(start_addr) <= int'(end_addr)) begin
            m_lo = int'(start_addr); m_hi = int'(end_addr);
            m_mode = (mode == 2'd3) ? 0 : int'(mode);
            m_k = 0; m_addr = m_lo; m_cnt = 0; m_cfg = 0; m_state = ST_RUN;
          end else begin
            m_cfg = 1; m_state = ST_IDLE;
          end
        end else begin
          case (m_state)
            ST_RUN: begin
              if (enable) begin
                iss = 1;
                m_k++;
                m_addr = exp_addr(m_k);
                m_cnt = exp_cnt(m_k);
                if (m_mode == 1 && m_k == m_hi - m_lo + 1) begin
                  m_state = ST_DONE; m_done = 1;
                end
              end else m_state = ST_PAUSE;
            end
            ST_PAUSE: if (enable) m_state = ST_RUN;
            ST_DONE:  if (empty) m_state = ST_IDLE;
            default: ;
          endcase
        end
        if (flush) begin
          m_sv = 0;
          for (int i = 0; i < ROM_LAT; i++) pv[i] = 0;
        end else begin
          m_sv = cap;
          if (cap) m_sout = rom_val(capa);
          for (int i = ROM_LAT - 1; i > 0; i--) begin pv[i] = pv[i-1]; pa[i] = pa[i-1]; end
          pv[0] = iss; pa[0] = ia;
        end
      end
    end
  end

  // every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        chk("cmp_address", int'(address), m_addr);
        chk("cmp_sample_valid", int'(sample_valid), int'(m_sv));
        chk("cmp_sample_out", int'(sample_out), m_sout);
        chk("cmp_busy", int'(busy), int'(m_state == ST_RUN || m_state == ST_PAUSE));
        chk("cmp_done", int'(done), int'(m_done));
        chk("cmp_cfg_err", int'(cfg_err), int'(m_cfg));
        chk("cmp_loop_count", int'(loop_count), m_cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic pulse_start(input int lo, input int hi, input int md);
    start_addr = ADDR_W'(lo);
    end_addr   = ADDR_W'(hi);
    mode       = 2'(md);
    start      = 1'b1;
    tick(1);
    start      = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  int gap, sv_cnt, strobes, dones;
  int vals [8];
  int seq [6];
  int lcs [6];
  int exp_os [4];
  int exp_pp [6];

  initial begin
    exp_os = '{375, 412, 449, 486};
    exp_pp = '{5, 6, 7, 6, 5, 6};
    reset = 1'b1; start = 0; stop = 0; enable = 0; mode = 0;
    start_addr = 0; end_addr = 0;
    #1 reset = 1'b0;
    #19;
    chk("rst_address", int'(address), 0);
    chk("rst_sample_valid", int'(sample_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_loop_count", int'(loop_count), 0);
    #2 reset = 1'b1;
    tick(1);
    chk_en = 1;

    // idle after reset with no start
    tick(5);
    chk("idle_address", int'(address), 0);
    chk("idle_busy", int'(busy), 0);

    // loop 0..511
    enable = 1'b1;
    pulse_start(0, 511, 0);
    chk("loop_first_addr", int'(address), 0);
    chk("loop_busy", int'(busy), 1);
    tick(1);
    chk("loop_addr1", int'(address), 1);
    chk("loop_no_early_sv", int'(sample_valid), 0);
    tick(1);
    chk("loop_first_sv", int'(sample_valid), 1);
    chk("loop_first_sample", int'(sample_out), 5);
    gap = 0;
    repeat (509) begin
      tick(1);
      if (!sample_valid) gap++;
    end
    chk("loop_sv_continuous", gap, 0);
    chk("loop_addr_511", int'(address), 511);
    chk("loop_lc_before_wrap", int'(loop_count), 0);
    tick(1);
    chk("loop_wrap_addr", int'(address), 0);
    chk("loop_wrap_lc", int'(loop_count), 1);
    pulse_stop();
    chk("stop_addr_hold", int'(address), 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_lc_hold", int'(loop_count), 1);
    sv_cnt = 0;
    repeat (5) begin
      if (sample_valid) sv_cnt++;
      tick(1);
    end
    chk("stop_no_strobe", sv_cnt, 0);

    // one-shot 10..13
    pulse_start(10, 13, 1);
    strobes = 0; dones = 0;
    repeat (12) begin
      if (sample_valid) begin
        if (strobes < 8) vals[strobes] = int'(sample_out);
        strobes++;
      end
      if (done) dones++;
      tick(1);
    end
    chk("os_strobes", strobes, 4);
    for (int i = 0; i < 4; i++) chk("os_sample", vals[i], exp_os[i]);
    chk("os_done_pulses", dones, 1);
    chk("os_busy_low", int'(busy), 0);
    chk("os_addr_hold", int'(address), 13);
    chk("os_sample_hold", int'(sample_out), 486);

    // ping-pong 5..7
    pulse_start(5, 7, 2);
    for (int i = 0; i < 6; i++) begin
      seq[i] = int'(address);
      lcs[i] = int'(loop_count);
      tick(1);
    end
    for (int i = 0; i < 6; i++) chk("pp_seq", seq[i], exp_pp[i]);
    chk("pp_lc_before_return", lcs[3], 0);
    chk("pp_lc_on_return", lcs[4], 1);
    pulse_stop();

    // pause and resume, loop 100..120
    pulse_start(100, 120, 0);
    tick(4);
    chk("pause_pre_addr", int'(address), 104);
    enable = 1'b0;
    tick(1);
    chk("pause_addr_a", int'(address), 104);
    chk("pause_inflight_sv", int'(sample_valid), 1);
    chk("pause_inflight_val", int'(sample_out), 744);
    tick(1);
    chk("pause_addr_b", int'(address), 104);
    chk("pause_no_new_sv", int'(sample_valid), 0);
    tick(1);
    chk("pause_addr_c", int'(address), 104);
    enable = 1'b1;
    tick(1);
    chk("resume_hold", int'(address), 104);
    tick(1);
    chk("resume_next", int'(address), 105);
    tick(1);
    chk("resume_sample", int'(sample_out), 781);
    pulse_stop();

    // configuration edges
    pulse_start(20, 10, 0);
    chk("cfg_err_set", int'(cfg_err), 1);
    chk("cfg_err_idle", int'(busy), 0);
    tick(2);
    chk("cfg_err_sticky", int'(cfg_err), 1);
    pulse_start(10, 20, 0);
    chk("cfg_err_clear", int'(cfg_err), 0);
    chk("cfg_good_busy", int'(busy), 1);
    pulse_stop();

    pulse_start(7, 7, 0);
    chk("single_addr", int'(address), 7);
    tick(1);
    chk("single_lc1", int'(loop_count), 1);
    tick(254);
    chk("single_lc255", int'(loop_count), 255);
    chk("single_addr_hold", int'(address), 7);
    tick(10);
    chk("single_lc_sat", int'(loop_count), 255);

    // asynchronous reset mid-run
    reset = 1'b0;
    #1;
    chk("areset_address", int'(address), 0);
    chk("areset_sample_out", int'(sample_out), 0);
    chk("areset_sample_valid", int'(sample_valid), 0);
    chk("areset_busy", int'(busy), 0);
    chk("areset_loop_count", int'(loop_count), 0);
    chk("areset_done", int'(done), 0);
    tick(2);
    reset = 1'b1;
    tick(5);
    chk("post_reset_addr", int'(address), 0);
    chk("post_reset_sv", int'(sample_valid), 0);
    chk("post_reset_busy", int'(busy), 0);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
